// File: rtl/parallel2serial_pkg.sv
// Shared definitions for the parallel2serial / serial2parallel link: frame
// length and the FSM state encoding both ends agree on.
package parallel2serial_pkg;

  localparam int P2S_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } p2s_state_e;

endpackage

// File: rtl/parallel2serial.sv
// Parallel-to-serial transmitter: sends a WIDTH-bit word LSB first with a
// shift strobe (sl), followed by one gap cycle that pulses done.
module parallel2serial
  import parallel2serial_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             q,
  output logic             sl,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  p2s_state_e       state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             q_nxt, sl_nxt, busy_nxt, done_nxt, ready_nxt;
  logic             accept;

  // ready is a registered copy of "not shifting", so accept never depends
  // combinationally on anything but load.
  assign accept = load && ready;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a value unassigned and no latch is inferred.
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    q_nxt     = 1'b0;
    sl_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    ready_nxt = 1'b1;
    case (state)
      ST_IDLE, ST_GAP: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
          sreg_nxt  = din;
          cnt_nxt   = '0;
          q_nxt     = din[0];
          sl_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_GAP;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          sreg_nxt  = sreg >> 1;
          q_nxt     = sreg[1];
          sl_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      q     <= 1'b0;
      sl    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      sl    <= sl_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_parallel2serial.sv
// Bench for parallel2serial: WIDTH=4 and WIDTH=2 instances, a frame-position
// reference model, a loopback word scoreboard and directed literal checks.
module tb_parallel2serial;

  logic       clk;
  logic       rst_a  [2];
  logic       load_a [2];
  logic [3:0] din_a  [2];
  logic       q_a    [2];
  logic       sl_a   [2];
  logic       busy_a [2];
  logic       done_a [2];
  logic       ready_a[2];

  int tests_run = 0;
  int failed    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  parallel2serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_(rst_a[0]), .din(din_a[0]), .load(load_a[0]),
    .ready(ready_a[0]), .q(q_a[0]), .sl(sl_a[0]), .busy(busy_a[0]), .done(done_a[0])
  );

  parallel2serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_(rst_a[1]), .din(din_a[1][1:0]), .load(load_a[1]),
    .ready(ready_a[1]), .q(q_a[1]), .sl(sl_a[1]), .busy(busy_a[1]), .done(done_a[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wd(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Reference model: pos = -1 idle, 0..W-1 bit on the line, W = gap cycle.
  int         pos    [2] = '{-1, -1};
  logic [3:0] word   [2];
  bit         started[2] = '{0, 0};
  bit         abort  [2] = '{0, 0};
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_a[i]) begin
        pos[i]     = -1;
        started[i] = 1'b1;
        abort[i]   = 1'b1;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else if ((pos[i] < 0 || pos[i] == wd(i)) && load_a[i]) begin
        pos[i]  = 0;
        word[i] = (i == 0) ? din_a[i] : (din_a[i] & 4'h3);
        if (i == 0) exp_q0.push_back(word[i]); else exp_q1.push_back(word[i]);
      end else if (pos[i] >= 0 && pos[i] < wd(i)) begin
        pos[i]++;
      end else begin
        pos[i] = -1;
      end
    end
  end

  // Per-cycle output compare; vector order is {q, sl, busy, done, ready}.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (started[i]) begin
        logic e_sl, e_q;
        e_sl = (pos[i] >= 0 && pos[i] < wd(i));
        e_q  = e_sl ? word[i][pos[i]] : 1'b0;
        check($sformatf("cycle_w%0d", wd(i)),
              {27'd0, q_a[i], sl_a[i], busy_a[i], done_a[i], ready_a[i]},
              {27'd0, e_q, e_sl, e_sl, (pos[i] == wd(i)), !e_sl});
      end
    end
  end

  // Loopback receiver: collect q while sl is high, compare the word when sl drops.
  int          nb     [2] = '{0, 0};
  logic [31:0] acc    [2] = '{0, 0};
  logic [31:0] rx_last[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!started[i]) begin
        nb[i] = 0;
      end else if (abort[i]) begin
        abort[i] = 1'b0;
        nb[i]    = 0;
        acc[i]   = 0;
      end else if (sl_a[i] === 1'b1) begin
        if (nb[i] < 32) acc[i][nb[i]] = q_a[i];
        nb[i]++;
      end else if (nb[i] != 0) begin
        logic [3:0] e;
        check($sformatf("frame_len_w%0d", wd(i)), nb[i], wd(i));
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          check($sformatf("rx_unexpected_w%0d", wd(i)), acc[i], 32'hFFFF_FFFF);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("rx_word_w%0d", wd(i)), acc[i], {28'd0, e});
        end
        rx_last[i] = acc[i];
        nb[i]      = 0;
        acc[i]     = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic l, input logic [3:0] d);
    rst_a[i]  = r;
    load_a[i] = l;
    din_a[i]  = d;
  endtask

  function automatic logic [4:0] outs(input int i);
    return {q_a[i], sl_a[i], busy_a[i], done_a[i], ready_a[i]};
  endfunction

  initial begin
    logic [4:0] exp28 [5];
    logic [4:0] exp30 [4];
    exp28 = '{5'b11100, 5'b11100, 5'b01100, 5'b11100, 5'b00011};
    exp30 = '{5'b11100, 5'b11100, 5'b01100, 5'b01100};

    drive(0, 1'b1, 1'b0, 4'h0);
    drive(1, 1'b1, 1'b0, 4'h0);
    tick();
    check("reset_w4", {27'd0, outs(0)}, 32'h01);
    check("reset_w2", {27'd0, outs(1)}, 32'h01);
    drive(0, 1'b0, 1'b0, 4'h0);
    drive(1, 1'b0, 1'b0, 4'h0);
    tick();

    // Single frame 4'b1011.
    drive(0, 1'b0, 1'b1, 4'b1011);
    tick();
    drive(0, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("single_c%0d", k + 1), {27'd0, outs(0)}, {27'd0, exp28[k]});
      if (k < 4) tick();
    end
    check("single_rx", rx_last[0], 32'hB);
    tick();

    // Back-to-back 4'hA then 4'h5 with load held.
    drive(0, 1'b0, 1'b1, 4'hA);
    tick();
    drive(0, 1'b0, 1'b1, 4'h5);
    for (int k = 0; k < 4; k++) tick();
    check("b2b_gap", {27'd0, outs(0)}, 32'h03);
    check("b2b_rx_a", rx_last[0], 32'hA);
    tick();
    check("b2b_second_start", {27'd0, outs(0)}, 32'h1C);
    drive(0, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) tick();
    check("b2b_rx_5", rx_last[0], 32'h5);
    tick();

    // Load ignored while shifting 4'h3.
    drive(0, 1'b0, 1'b1, 4'h3);
    tick();
    drive(0, 1'b0, 1'b1, 4'hF);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ignore_c%0d", k + 1), {27'd0, outs(0)}, {27'd0, exp30[k]});
      if (k == 3) drive(0, 1'b0, 1'b0, 4'h0);
      tick();
    end
    check("ignore_rx", rx_last[0], 32'h3);
    tick();

    // Reset at bit 2 of 4'h6.
    drive(0, 1'b0, 1'b1, 4'h6);
    tick();
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    check("midrst_bit2", {27'd0, outs(0)}, 32'h1C);
    drive(0, 1'b1, 1'b0, 4'h0);
    tick();
    check("midrst_after", {27'd0, outs(0)}, 32'h01);
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    check("midrst_no_done", {27'd0, outs(0)}, 32'h01);

    // Reset and load on the same edge.
    drive(0, 1'b1, 1'b1, 4'hF);
    tick();
    check("rst_load", {27'd0, outs(0)}, 32'h01);
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    check("rst_load_idle", {27'd0, outs(0)}, 32'h01);

    // WIDTH=2 boundary: 2'b10.
    drive(1, 1'b0, 1'b1, 4'b0010);
    tick();
    drive(1, 1'b0, 1'b0, 4'h0);
    check("w2_bit0", {27'd0, outs(1)}, 32'h0C);
    tick();
    check("w2_bit1", {27'd0, outs(1)}, 32'h1C);
    tick();
    check("w2_gap", {27'd0, outs(1)}, 32'h03);
    check("w2_rx", rx_last[1], 32'h2);
    tick();

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        drive(i, ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      tick();
    end
    drive(0, 1'b0, 1'b0, 4'h0);
    drive(1, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 8; k++) tick();
    check("drain_w4", exp_q0.size(), 0);
    check("drain_w2", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/parallel2serial.md
PARALLEL2SERIAL -- requirements
Module: parallel2serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the frame length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the only clock; all logic updates on the rising edge.
REQ-003 SHALL have port rst_  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port din  input  WIDTH  parallel word to transmit.
REQ-005 SHALL have port load  input  1  request: din is valid this cycle.
REQ-006 SHALL have port ready  output  1  block can accept din this cycle.
REQ-007 SHALL have port q  output  1  serial data, LSB first, registered.
REQ-008 SHALL have port sl  output  1  shift-enable strobe for the serial2parallel receiver, registered.
REQ-009 SHALL have port busy  output  1  high while a frame is shifting.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking the end-of-frame gap cycle.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and GAP.
REQ-012 SHALL drive ready high in IDLE and GAP, and low in SHIFT.
REQ-013 SHALL accept a word on any rising edge where load && ready; a word is captured only on accept.
REQ-014 SHALL, on accept: capture din into the shift register, clear the bit counter, set q=din[0], set sl=1, and enter SHIFT.
REQ-015 SHALL, in SHIFT, hold sl=1 and present bit k of the captured word on q during the k-th cycle after accept, for k=0..WIDTH-1.
REQ-016 SHALL hold sl=1 for exactly WIDTH consecutive cycles per frame.
REQ-017 SHALL, after bit WIDTH-1, enter GAP for exactly one cycle with sl=0, q=0, busy=0 and done=1.
REQ-018 SHALL, from GAP, go to SHIFT if a word is accepted and otherwise to IDLE; back-to-back frame period is WIDTH+1 cycles, with sl low for exactly one cycle between frames.
REQ-019 SHALL ignore load and din while in SHIFT; the frame in progress is never corrupted or extended.
REQ-020 SHALL hold q=0, sl=0 and done=0 in IDLE.
REQ-021 SHALL size the bit counter as $clog2(WIDTH) bits and compare it against WIDTH-1 without wrap-around.
REQ-022 SHALL register every output, with no combinational path from inputs to q, sl or done.

Reset
REQ-023 SHALL, when rst_=1 at a rising edge, set state=IDLE, the shift register and counter to 0, and outputs q=0, sl=0, busy=0, done=0, ready=1 on the following cycle.
REQ-024 SHALL, on reset mid-frame, abandon the frame and never resume it; sl drops on the reset edge.
REQ-025 SHALL give reset priority over simultaneous load.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE/SHIFT/GAP) and the default WIDTH constant in the shared p2s/s2p package, so that serial2parallel and parallel2serial agree on the frame length.
REQ-027 SHALL be a single flat module with no sub-module, as the counter and shifter are too small to justify one.

Verification
REQ-028 SHALL verify the single frame with WIDTH=4: din=4'b1011 and load pulsed once in IDLE -> q=1,1,0,1 in cycles 1-4 with sl=1, then cycle 5 has sl=0 and done=1; a serial2parallel receiver in loopback gives so=4'b1011.
REQ-029 SHALL verify back-to-back frames: load held high with din=4'hA then 4'h5 -> the second accept occurs in GAP, sl is low for exactly 1 cycle, and the receiver outputs 4'hA then 4'h5.
REQ-030 SHALL verify busy-ignore: load=1 with din=4'hF in every SHIFT cycle of the 4'h3 frame -> q=1,1,0,0, with ready=0 throughout SHIFT.
REQ-031 SHALL verify reset mid-frame: rst_=1 at bit 2 of 4'h6 -> next cycle has sl=0, q=0, busy=0, ready=1, and no done pulse.
REQ-032 SHALL verify reset with load: rst_=1 and load=1 on the same edge -> state is IDLE, sl=0, and no frame starts.
REQ-033 SHALL verify the boundary WIDTH=2: din=2'b10 -> q=0,1 with sl high exactly 2 cycles, then done.
